commit_trace_buffer: RTL and testbench

- Hardware retirement-trace capture block sitting directly downstream of the processor's commit point.
- Consumes the per-cycle architectural commit signals: PC, register write, memory access and halt.
- Queues one record per committed instruction in a FIFO, with instruction number, cycle count and instruction count.
- Drains records through a valid/ready port to a host/debug reader; the on-chip equivalent of the simulation trace/log.

---
 rtl/commit_trace_buffer_pkg.sv | 48 ++++
 rtl/commit_trace_buffer_if.sv | 40 ++++
 rtl/commit_trace_buffer_trace_fifo.sv | 53 +++++
 rtl/commit_trace_buffer.sv | 136 +++++++++++++
 tb/tb_commit_trace_buffer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer: FSM states, record layout and flag bit positions.
package commit_trace_buffer_pkg;

    localparam int unsigned CTB_CNT_W = 32;
    localparam int unsigned PC_W      = 16;
    localparam int unsigned REG_W     = 3;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned FLAGS_W   = 5;

    localparam int unsigned FLAG_VALID     = 0;
    localparam int unsigned FLAG_REG_WRITE = 1;
    localparam int unsigned FLAG_MEM_READ  = 2;
    localparam int unsigned FLAG_MEM_WRITE = 3;
    localparam int unsigned FLAG_HALT      = 4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2,
        DONE      = 2'd3
    } ctbState_e;

    // Record body; the instruction number is prepended by the top since its width is a parameter.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [REG_W-1:0]   wreg;
        logic [DATA_W-1:0]  wdata;
        logic [ADDR_W-1:0]  maddr;
        logic [DATA_W-1:0]  mdata;
        logic [FLAGS_W-1:0] flags;
    } recPayload_t;

    localparam int unsigned PAYLOAD_W = $bits(recPayload_t);

    function automatic logic [FLAGS_W-1:0] makeFlags(input logic halt, input logic memWrite,
                                                     input logic memRead, input logic regWrite);
        logic [FLAGS_W-1:0] f;
        f                 = '0;
        f[FLAG_VALID]     = 1'b1;
        f[FLAG_REG_WRITE] = regWrite;
        f[FLAG_MEM_READ]  = memRead;
        f[FLAG_MEM_WRITE] = memWrite;
        f[FLAG_HALT]      = halt;
        return f;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side inputs and record drain port of the commit trace buffer.
interface commit_trace_buffer_if #(
    parameter int unsigned CNT_W = 32
);
    import commit_trace_buffer_pkg::*;

    logic               commit;
    logic [PC_W-1:0]    PC;
    logic               RegWrite;
    logic [REG_W-1:0]   WriteRegister;
    logic [DATA_W-1:0]  WriteData;
    logic               MemRead;
    logic               MemWrite;
    logic [ADDR_W-1:0]  MemAddress;
    logic [DATA_W-1:0]  MemData;
    logic               Halt;

    logic               rec_valid;
    logic               rec_ready;
    logic [CNT_W-1:0]   rec_inum;
    logic [PC_W-1:0]    rec_pc;
    logic [DATA_W-1:0]  rec_wdata;
    logic [ADDR_W-1:0]  rec_maddr;
    logic [DATA_W-1:0]  rec_mdata;
    logic [REG_W-1:0]   rec_wreg;
    logic [FLAGS_W-1:0] rec_flags;

    modport master (
        output commit, PC, RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
               MemAddress, MemData, Halt, rec_ready,
        input  rec_valid, rec_inum, rec_pc, rec_wdata, rec_maddr, rec_mdata, rec_wreg, rec_flags
    );

    modport slave (
        input  commit, PC, RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
               MemAddress, MemData, Halt, rec_ready,
        output rec_valid, rec_inum, rec_pc, rec_wdata, rec_maddr, rec_mdata, rec_wreg, rec_flags
    );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty are registered from the next pointers.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr, wrNext, rdNext;
    logic             doPush, doPop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_comb begin
        wrNext = wrPtr;
        rdNext = rdPtr;
        if (doPush) wrNext = wrPtr + PW'(1);
        if (doPop)  rdNext = rdPtr + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wrPtr <= wrNext;
            rdPtr <= rdNext;
            empty <= (wrNext == rdNext);
            full  <= (wrNext[AW] != rdNext[AW]) && (wrNext[AW-1:0] == rdNext[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

    assign popData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: one record per committed instruction, queued and drained over valid/ready.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = CTB_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    commit_trace_buffer_if.slave      bus,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          inst_count,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      overflow,
    output logic                      halted,
    output logic                      done
);
    localparam int unsigned REC_W = CNT_W + PAYLOAD_W;

    ctbState_e          state, nextState;
    recPayload_t        commitPayload, headPayload;
    logic [CNT_W-1:0]   headInum;
    logic [REC_W-1:0]   commitRec, haltPend, pushRec, popRec;
    logic               fifoPush, fifoFull, fifoEmpty, pop, spaceOk;
    logic               instInc, cycleInc, dropInc, latchHalt;

    assign commitPayload = '{
        pc:    bus.PC,
        wreg:  bus.WriteRegister,
        wdata: bus.WriteData,
        maddr: bus.MemAddress,
        mdata: bus.MemData,
        flags: makeFlags(bus.Halt, bus.MemWrite, bus.MemRead, bus.RegWrite)
    };
    assign commitRec = {inst_count, commitPayload};

    assign pop     = !fifoEmpty && bus.rec_ready;
    assign spaceOk = !fifoFull || pop;

    trace_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushData (pushRec),
        .pop      (pop),
        .popData  (popRec),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nextState;
            halted <= (nextState == HALTED) || (nextState == DONE);
            done   <= (nextState == DONE);
        end
    end

    // Capture/halt sequencing; commits are only observed in RUN.
    always_comb begin
        nextState = state;
        fifoPush  = 1'b0;
        pushRec   = commitRec;
        instInc   = 1'b0;
        cycleInc  = 1'b0;
        dropInc   = 1'b0;
        latchHalt = 1'b0;
        unique case (state)
            RUN: begin
                cycleInc = !(bus.commit && bus.Halt);
                if (bus.commit) begin
                    instInc = 1'b1;
                    if (spaceOk) begin
                        fifoPush = 1'b1;
                        if (bus.Halt) nextState = HALTED;
                    end else if (bus.Halt) begin
                        latchHalt = 1'b1;
                        nextState = HALT_PEND;
                    end else begin
                        dropInc = 1'b1;
                    end
                end
            end
            HALT_PEND: begin
                if (pop) begin
                    fifoPush  = 1'b1;
                    pushRec   = haltPend;
                    nextState = HALTED;
                end
            end
            HALTED: begin
                if (fifoEmpty) nextState = DONE;
            end
            DONE: begin
                nextState = DONE;
            end
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            haltPend    <= '0;
        end else begin
            if (cycleInc)  cycle_count <= cycle_count + CNT_W'(1);
            if (instInc)   inst_count  <= inst_count + CNT_W'(1);
            if (dropInc)   drop_count  <= drop_count + CNT_W'(1);
            if (dropInc)   overflow    <= 1'b1;
            if (latchHalt) haltPend    <= commitRec;
        end
    end

    // Head fields read as zero whenever nothing is queued.
    assign {headInum, headPayload} = fifoEmpty ? '0 : popRec;

    assign bus.rec_valid = !fifoEmpty;
    assign bus.rec_inum  = headInum;
    assign bus.rec_pc    = headPayload.pc;
    assign bus.rec_wreg  = headPayload.wreg;
    assign bus.rec_wdata = headPayload.wdata;
    assign bus.rec_maddr = headPayload.maddr;
    assign bus.rec_mdata = headPayload.mdata;
    assign bus.rec_flags = headPayload.flags;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: vector table plus multi-cycle corner sequences.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cycle_count, inst_count, drop_count;
    logic             overflow, halted, done;

    always #5 clk = ~clk;

    commit_trace_buffer_if #(.CNT_W(CNT_W)) bus ();

    commit_trace_buffer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .cycle_count (cycle_count),
        .inst_count  (inst_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .halted      (halted),
        .done        (done)
    );

    typedef struct {
        logic        commit;
        logic [15:0] pc;
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        mr;
        logic        mw;
        logic [15:0] ma;
        logic [15:0] md;
        logic        halt;
        logic        ready;
        logic        expValid;
        logic [31:0] expInum;
        logic [15:0] expPc;
        logic [4:0]  expFlags;
        logic [2:0]  expWr;
        logic [15:0] expWd;
        logic [15:0] expMa;
        logic [15:0] expMd;
        logic [31:0] expInst;
    } vec_t;

    vec_t vecs [5];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.commit        = 1'b0;
        bus.PC            = '0;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.MemAddress    = '0;
        bus.MemData       = '0;
        bus.Halt          = 1'b0;
    endtask

    task automatic drive(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                         input logic [15:0] wd, input logic mr, input logic mw,
                         input logic [15:0] ma, input logic [15:0] md, input logic h);
        bus.commit        = 1'b1;
        bus.PC            = pc;
        bus.RegWrite      = rw;
        bus.WriteRegister = wr;
        bus.WriteData     = wd;
        bus.MemRead       = mr;
        bus.MemWrite      = mw;
        bus.MemAddress    = ma;
        bus.MemData       = md;
        bus.Halt          = h;
    endtask

    task automatic simple(input logic [15:0] pc);
        drive(pc, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.rec_ready = 1'b0;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                    1'b1, 32'd0, 16'h0000, 5'b00011, 3'd1, 16'h0005, 16'h0000, 16'h0000, 32'd1};
        vecs[1] = '{1'b1, 16'h0002, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0005, 1'b0, 1'b1,
                    1'b1, 32'd1, 16'h0002, 5'b01001, 3'd0, 16'h0000, 16'h0010, 16'h0005, 32'd2};
        vecs[2] = '{1'b1, 16'h0004, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                    1'b1, 32'd2, 16'h0004, 5'b00001, 3'd0, 16'h0000, 16'h0000, 16'h0000, 32'd3};
        vecs[3] = '{1'b1, 16'h0006, 1'b1, 3'd2, 16'h1234, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1,
                    1'b1, 32'd3, 16'h0006, 5'b00111, 3'd2, 16'h1234, 16'h0020, 16'h0000, 32'd4};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                    1'b0, 32'd0, 16'h0000, 5'b00000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 32'd4};

        // Reset state
        doReset();
        check("rst.valid", 64'(bus.rec_valid), 64'd0);
        check("rst.inst", 64'(inst_count), 64'd0);
        check("rst.cycle", 64'(cycle_count), 64'd0);
        check("rst.flags", 64'(bus.rec_flags), 64'd0);
        check("rst.halted", 64'(halted), 64'd0);

        // Basic capture table
        foreach (vecs[i]) begin
            if (vecs[i].commit)
                drive(vecs[i].pc, vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].mr, vecs[i].mw,
                      vecs[i].ma, vecs[i].md, vecs[i].halt);
            else
                idle();
            bus.rec_ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d.valid", i), 64'(bus.rec_valid), 64'(vecs[i].expValid));
            check($sformatf("vec%0d.inum", i),  64'(bus.rec_inum),  64'(vecs[i].expInum));
            check($sformatf("vec%0d.pc", i),    64'(bus.rec_pc),    64'(vecs[i].expPc));
            check($sformatf("vec%0d.flags", i), 64'(bus.rec_flags), 64'(vecs[i].expFlags));
            check($sformatf("vec%0d.wreg", i),  64'(bus.rec_wreg),  64'(vecs[i].expWr));
            check($sformatf("vec%0d.wdata", i), 64'(bus.rec_wdata), 64'(vecs[i].expWd));
            check($sformatf("vec%0d.maddr", i), 64'(bus.rec_maddr), 64'(vecs[i].expMa));
            check($sformatf("vec%0d.mdata", i), 64'(bus.rec_mdata), 64'(vecs[i].expMd));
            check($sformatf("vec%0d.inst", i),  64'(inst_count),    64'(vecs[i].expInst));
        end
        check("vec.cycle", 64'(cycle_count), 64'd5);

        // Overflow: 20 commits into 16 slots with the reader stalled
        doReset();
        for (int i = 0; i < 20; i++) begin
            simple(16'(2 * i));
            step();
        end
        idle();
        check("ovf.overflow", 64'(overflow), 64'd1);
        check("ovf.drop", 64'(drop_count), 64'd4);
        check("ovf.inst", 64'(inst_count), 64'd20);
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovf.inum%0d", k), 64'(bus.rec_inum), 64'(k));
            check($sformatf("ovf.pc%0d", k), 64'(bus.rec_pc), 64'(2 * k));
            step();
        end
        check("ovf.empty", 64'(bus.rec_valid), 64'd0);

        // Halt commits into a full FIFO
        doReset();
        for (int i = 0; i < 16; i++) begin
            simple(16'(2 * i));
            step();
        end
        check("hp.cycleBefore", 64'(cycle_count), 64'd16);
        drive(16'h0040, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();
        simple(16'h0099);
        for (int i = 0; i < 3; i++) step();
        check("hp.inst", 64'(inst_count), 64'd17);
        check("hp.drop", 64'(drop_count), 64'd0);
        check("hp.halted", 64'(halted), 64'd0);
        check("hp.cycle", 64'(cycle_count), 64'd16);
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("hp.inum%0d", k), 64'(bus.rec_inum), 64'(k));
            step();
        end
        idle();
        check("hp.haltValid", 64'(bus.rec_valid), 64'd1);
        check("hp.haltInum", 64'(bus.rec_inum), 64'd16);
        check("hp.haltPc", 64'(bus.rec_pc), 64'h0040);
        check("hp.haltFlags", 64'(bus.rec_flags), 64'b10001);
        check("hp.haltedSet", 64'(halted), 64'd1);
        check("hp.instIgnored", 64'(inst_count), 64'd17);
        step();
        check("hp.drained", 64'(bus.rec_valid), 64'd0);
        begin
            int waitCyc = 0;
            while (!done && waitCyc < 4) begin
                step();
                waitCyc++;
            end
        end
        check("hp.done", 64'(done), 64'd1);
        check("hp.doneHalted", 64'(halted), 64'd1);
        check("hp.cycleFrozen", 64'(cycle_count), 64'd16);

        // Full FIFO with simultaneous push and pop
        doReset();
        for (int i = 0; i < 16; i++) begin
            simple(16'(16'h0100 + i));
            step();
        end
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            simple(16'(16'h0200 + k));
            check($sformatf("pp.inum%0d", k), 64'(bus.rec_inum), 64'(k));
            step();
        end
        idle();
        bus.rec_ready = 1'b0;
        check("pp.drop", 64'(drop_count), 64'd0);
        check("pp.overflow", 64'(overflow), 64'd0);
        check("pp.inst", 64'(inst_count), 64'd26);
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("pp.drain%0d", k), 64'(bus.rec_inum), 64'(10 + k));
            step();
        end
        check("pp.empty", 64'(bus.rec_valid), 64'd0);

        // Reset while halted with records queued
        doReset();
        for (int i = 0; i < 4; i++) begin
            simple(16'(16'h0300 + i));
            step();
        end
        drive(16'h0310, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();
        idle();
        check("rh.halted", 64'(halted), 64'd1);
        check("rh.inst", 64'(inst_count), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rh.valid", 64'(bus.rec_valid), 64'd0);
        check("rh.cycle", 64'(cycle_count), 64'd0);
        check("rh.inst0", 64'(inst_count), 64'd0);
        check("rh.drop", 64'(drop_count), 64'd0);
        check("rh.halted0", 64'(halted), 64'd0);
        check("rh.done", 64'(done), 64'd0);
        check("rh.pc", 64'(bus.rec_pc), 64'd0);
        simple(16'h0400);
        step();
        idle();
        check("rh.newValid", 64'(bus.rec_valid), 64'd1);
        check("rh.newInum", 64'(bus.rec_inum), 64'd0);
        check("rh.newPc", 64'(bus.rec_pc), 64'h0400);

        // Head stability while the reader stalls and commits keep arriving
        doReset();
        drive(16'h0abc, 1'b1, 3'd5, 16'hbeef, 1'b0, 1'b1, 16'h1357, 16'h2468, 1'b0);
        step();
        simple(16'h0ddd);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("st%0d.valid", c), 64'(bus.rec_valid), 64'd1);
            check($sformatf("st%0d.inum", c),  64'(bus.rec_inum),  64'd0);
            check($sformatf("st%0d.pc", c),    64'(bus.rec_pc),    64'h0abc);
            check($sformatf("st%0d.flags", c), 64'(bus.rec_flags), 64'b01011);
            check($sformatf("st%0d.wreg", c),  64'(bus.rec_wreg),  64'd5);
            check($sformatf("st%0d.wdata", c), 64'(bus.rec_wdata), 64'hbeef);
            check($sformatf("st%0d.maddr", c), 64'(bus.rec_maddr), 64'h1357);
            check($sformatf("st%0d.mdata", c), 64'(bus.rec_mdata), 64'h2468);
            step();
        end
        idle();
        bus.rec_ready = 1'b1;
        step();
        check("st.nextInum", 64'(bus.rec_inum), 64'd1);
        check("st.nextPc", 64'(bus.rec_pc), 64'h0ddd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
